sdram_rd_arbiter: RTL and testbench

//  Shares the single SDRAM read port between two requesters.
//  - The MTL display refresh path is hard real-time and has absolute priority.
//  - Game/sprite logic issues atomic read bursts, which fit into H/V blanking.
//  - Tracks in-flight reads by owner tag and routes returned words to the

---
 rtl/sdram_rd_arbiter_if.sv | 43 ++++
 rtl/sdram_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_sdram_rd_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_rd_arbiter_if.sv
// sdram_rd_arbiter_if
//   Bundles the display, game and SDRAM-side signals of the SDRAM read arbiter.
//   slave  : the arbiter's view (requests in, data/strobes out)
//   master : the surrounding logic's view (LCD timing, game logic, SDRAM model)
//   Display : iDISP_RD/iDISP_ADDR in, oDISP_DATA/oDISP_VALID out
//   Game    : iGAME_REQ/ADDR/LEN in, oGAME_ACK/DATA/VALID/DONE out
//   Timing  : iFREE_CNT = cycles until the display next reads
//   SDRAM   : oMEM_RD/oMEM_ADDR out, iMEM_DATA in
//   Status  : oCONFLICT, oLEN_ERR (sticky)
interface sdram_rd_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              iDISP_RD;
  logic [ADDR_W-1:0] iDISP_ADDR;
  logic [DATA_W-1:0] oDISP_DATA;
  logic              oDISP_VALID;
  logic [10:0]       iFREE_CNT;
  logic              iGAME_REQ;
  logic [ADDR_W-1:0] iGAME_ADDR;
  logic [4:0]        iGAME_LEN;
  logic              oGAME_ACK;
  logic [DATA_W-1:0] oGAME_DATA;
  logic              oGAME_VALID;
  logic              oGAME_DONE;
  logic              oMEM_RD;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [DATA_W-1:0] iMEM_DATA;
  logic              oCONFLICT;
  logic              oLEN_ERR;

  modport slave (
    input  iDISP_RD, iDISP_ADDR, iFREE_CNT, iGAME_REQ, iGAME_ADDR, iGAME_LEN, iMEM_DATA,
    output oDISP_DATA, oDISP_VALID, oGAME_ACK, oGAME_DATA, oGAME_VALID, oGAME_DONE,
           oMEM_RD, oMEM_ADDR, oCONFLICT, oLEN_ERR
  );

  modport master (
    output iDISP_RD, iDISP_ADDR, iFREE_CNT, iGAME_REQ, iGAME_ADDR, iGAME_LEN, iMEM_DATA,
    input  oDISP_DATA, oDISP_VALID, oGAME_ACK, oGAME_DATA, oGAME_VALID, oGAME_DONE,
           oMEM_RD, oMEM_ADDR, oCONFLICT, oLEN_ERR
  );
endinterface

// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter
//   Shares the single SDRAM read port between the display refresh path
//   (absolute priority, never stalled) and atomic game read bursts that are
//   only started when they fit before the next display read.
//   Ports:
//     iCLK  - LCD/system clock
//     iRST  - synchronous reset, active-high
//     bus   - sdram_rd_arbiter_if.slave (display, game, SDRAM, status)
//   Read data is routed back by an owner tag that travels alongside each
//   issued read; the tag reaches the output stage exactly when iMEM_DATA
//   for that read is valid, so data is forwarded combinationally.
module sdram_rd_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic iCLK,
  input  logic iRST,
  sdram_rd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN, LERR} state_t;

  localparam logic [5:0]  MAXB = 6'(MAX_BURST);
  localparam logic [11:0] SLACK = 12'(RD_LAT + 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] gaddr, gaddr_d;
  logic [4:0]        rem, rem_d;
  logic              mem_rd, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr, mem_addr_d;
  logic              ack, ack_d, done, done_d;
  logic              conflict, conflict_d, len_err, len_err_d;
  logic              issue_game;
  // Stage 0 lines up with oMEM_RD; stage RD_LAT lines up with iMEM_DATA.
  logic [RD_LAT:0]   vld_pipe, own_pipe;   // own: 1 = game, 0 = display
  logic              disp_v, game_v;
  logic              can_accept, len_ok, game_early;
  logic [11:0]       need;

  assign need       = 12'(bus.iGAME_LEN) + SLACK;
  assign can_accept = bus.iGAME_REQ & ~bus.iDISP_RD & ({1'b0, bus.iFREE_CNT} >= need);
  assign len_ok     = (bus.iGAME_LEN != 5'd0) && ({1'b0, bus.iGAME_LEN} <= MAXB);
  // Game reads still short of the output stage. When none remain, the last
  // game word (if any) is on oGAME_VALID this cycle, so DONE lands right after.
  assign game_early = |(vld_pipe[RD_LAT-1:0] & own_pipe[RD_LAT-1:0]);

  always_comb begin
    state_d    = state;
    gaddr_d    = gaddr;
    rem_d      = rem;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    conflict_d = conflict;
    len_err_d  = len_err;
    issue_game = 1'b0;
    case (state)
      IDLE: if (can_accept) begin
        ack_d   = 1'b1;
        gaddr_d = bus.iGAME_ADDR;
        rem_d   = bus.iGAME_LEN;
        if (len_ok) state_d = BURST;
        else begin
          // Acked but no reads; LERR blocks re-accepting the still-held request.
          state_d   = LERR;
          len_err_d = 1'b1;
        end
      end
      BURST: if (bus.iDISP_RD) conflict_d = 1'b1;
      else begin
        issue_game = 1'b1;
        gaddr_d    = gaddr + ADDR_W'(1);
        rem_d      = rem - 5'd1;
        if (rem == 5'd1) state_d = DRAIN;
      end
      DRAIN: if (!game_early) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      LERR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_rd_d   = bus.iDISP_RD | issue_game;
    mem_addr_d = bus.iDISP_RD ? bus.iDISP_ADDR : (issue_game ? gaddr : mem_addr);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      gaddr    <= '0;
      rem      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ack      <= 1'b0;
      done     <= 1'b0;
      conflict <= 1'b0;
      len_err  <= 1'b0;
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      state    <= state_d;
      gaddr    <= gaddr_d;
      rem      <= rem_d;
      mem_rd   <= mem_rd_d;
      mem_addr <= mem_addr_d;
      ack      <= ack_d;
      done     <= done_d;
      conflict <= conflict_d;
      len_err  <= len_err_d;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], mem_rd_d};
      own_pipe <= {own_pipe[RD_LAT-1:0], issue_game};
    end
  end

  assign disp_v = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
  assign game_v = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];

  assign bus.oMEM_RD     = mem_rd;
  assign bus.oMEM_ADDR   = mem_addr;
  assign bus.oDISP_VALID = disp_v;
  assign bus.oDISP_DATA  = disp_v ? bus.iMEM_DATA : '0;
  assign bus.oGAME_VALID = game_v;
  assign bus.oGAME_DATA  = game_v ? bus.iMEM_DATA : '0;
  assign bus.oGAME_ACK   = ack;
  assign bus.oGAME_DONE  = done;
  assign bus.oCONFLICT   = conflict;
  assign bus.oLEN_ERR    = len_err;
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
module tb_sdram_rd_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sdram_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_BURST(16)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  // SDRAM model: data for an address appears two cycles after it is presented.
  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= bus.oMEM_ADDR;
    a2 <= a1;
  end
  assign bus.iMEM_DATA = {9'h0, a2} ^ 32'hA500_0000;

  int tests = 0, fails = 0, n = 0, both_cnt = 0, disp_at = -1;
  logic [AW-1:0] disp_adr = '0;
  int rd_cyc[$], gv_cyc[$], dv_cyc[$], ack_cyc[$], done_cyc[$];
  logic [31:0] rd_adr[$], gv_dat[$], dv_dat[$];
  logic [31:0] e[4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {25'b0, bus.oMEM_RD, bus.oGAME_ACK, bus.oGAME_DONE, bus.oDISP_VALID,
            bus.oGAME_VALID, bus.oCONFLICT, bus.oLEN_ERR};
  endfunction

  task automatic step();
    @(negedge clk);
    n++;
    if (bus.oMEM_RD)     begin rd_cyc.push_back(n); rd_adr.push_back(32'(bus.oMEM_ADDR)); end
    if (bus.oGAME_VALID) begin gv_cyc.push_back(n); gv_dat.push_back(bus.oGAME_DATA); end
    if (bus.oDISP_VALID) begin dv_cyc.push_back(n); dv_dat.push_back(bus.oDISP_DATA); end
    if (bus.oGAME_ACK)   ack_cyc.push_back(n);
    if (bus.oGAME_DONE)  done_cyc.push_back(n);
    if (bus.oGAME_VALID && bus.oDISP_VALID) both_cnt++;
  endtask

  task automatic clr();
    n = 0;
    rd_cyc.delete(); rd_adr.delete(); gv_cyc.delete(); gv_dat.delete();
    dv_cyc.delete(); dv_dat.delete(); ack_cyc.delete(); done_cyc.delete();
  endtask

  task automatic drv_disp();
    bus.iDISP_RD   = (n == disp_at);
    bus.iDISP_ADDR = disp_adr;
  endtask

  // Steps k cycles; the requester drops its request once it sees the ack.
  task automatic run(input int k);
    repeat (k) begin
      step();
      if (bus.oGAME_ACK) bus.iGAME_REQ = 1'b0;
      drv_disp();
    end
  endtask

  task automatic req(input logic [AW-1:0] a, input logic [4:0] l);
    bus.iGAME_REQ  = 1'b1;
    bus.iGAME_ADDR = a;
    bus.iGAME_LEN  = l;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iDISP_RD = 1'b0; bus.iDISP_ADDR = '0; bus.iFREE_CNT = '0;
    bus.iGAME_REQ = 1'b0; bus.iGAME_ADDR = '0; bus.iGAME_LEN = '0;
    repeat (3) step();
    chk("rst_flags", flags(), 32'h0);
    chk("rst_addr", 32'(bus.oMEM_ADDR), 32'h0);
    rst = 1'b0;
    step();

    // 1: display read latency
    clr(); disp_adr = 23'h100; disp_at = 0; drv_disp();
    run(6); disp_at = -1;
    chk("t1_rd_n", rd_cyc.size(), 1);
    chk("t1_rd_cyc", qi(rd_cyc, 0), 1);
    chk("t1_rd_adr", qd(rd_adr, 0), 32'h100);
    chk("t1_dv_cyc", qi(dv_cyc, 0), 3);
    chk("t1_dv_dat", qd(dv_dat, 0), 32'hA500_0100);
    chk("t1_gv_n", gv_cyc.size(), 0);

    // 2: wrapping game burst
    bus.iFREE_CNT = 11'd200;
    clr(); req(23'h7FFFFE, 5'd4); run(12);
    chk("t2_ack", qi(ack_cyc, 0), 1);
    e = '{32'h7FFFFE, 32'h7FFFFF, 32'h0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd_adr", qd(rd_adr, i), e[i]);
      chk("t2_rd_cyc", qi(rd_cyc, i), 2 + i);
    end
    e = '{32'hA57F_FFFE, 32'hA57F_FFFF, 32'hA500_0000, 32'hA500_0001};
    for (int i = 0; i < 4; i++) begin
      chk("t2_gv_dat", qd(gv_dat, i), e[i]);
      chk("t2_gv_cyc", qi(gv_cyc, i), 4 + i);
    end
    chk("t2_gv_n", gv_cyc.size(), 4);
    chk("t2_done_n", done_cyc.size(), 1);
    chk("t2_done_cyc", qi(done_cyc, 0), 8);

    // 3: insufficient free time holds the request
    bus.iFREE_CNT = 11'd6;
    clr(); req(23'h200, 5'd4); run(4);
    chk("t3_noack", ack_cyc.size(), 0);
    chk("t3_nord", rd_cyc.size(), 0);
    clr(); bus.iFREE_CNT = 11'd7; run(12);
    chk("t3_ack", qi(ack_cyc, 0), 1);
    chk("t3_gv_n", gv_cyc.size(), 4);
    chk("t3_done", qi(done_cyc, 0), 8);
    chk("t3_conf0", 32'(bus.oCONFLICT), 32'h0);

    // 4: display preempts the 2nd burst word
    bus.iFREE_CNT = 11'd200;
    clr(); disp_adr = 23'h0AA; disp_at = 2; req(23'h300, 5'd4); run(12); disp_at = -1;
    e = '{32'h300, 32'h0AA, 32'h301, 32'h302};
    for (int i = 0; i < 4; i++) chk("t4_rd_adr", qd(rd_adr, i), e[i]);
    chk("t4_rd_adr4", qd(rd_adr, 4), 32'h303);
    chk("t4_rd_last", qi(rd_cyc, 4), 6);
    e = '{32'hA500_0300, 32'hA500_0301, 32'hA500_0302, 32'hA500_0303};
    for (int i = 0; i < 4; i++) chk("t4_gv_dat", qd(gv_dat, i), e[i]);
    chk("t4_gv_cyc1", qi(gv_cyc, 1), 6);
    chk("t4_dv_cyc", qi(dv_cyc, 0), 5);
    chk("t4_dv_dat", qd(dv_dat, 0), 32'hA500_00AA);
    chk("t4_done", qi(done_cyc, 0), 9);
    chk("t4_conf", 32'(bus.oCONFLICT), 32'h1);

    // 5: illegal lengths
    chk("t5_lerr0", 32'(bus.oLEN_ERR), 32'h0);
    clr(); req(23'h400, 5'd0); run(4);
    chk("t5a_ack", qi(ack_cyc, 0), 1);
    chk("t5a_done", qi(done_cyc, 0), 2);
    chk("t5a_done_n", done_cyc.size(), 1);
    chk("t5a_nord", rd_cyc.size(), 0);
    chk("t5a_lerr", 32'(bus.oLEN_ERR), 32'h1);
    clr(); req(23'h400, 5'd17); run(4);
    chk("t5b_ack", qi(ack_cyc, 0), 1);
    chk("t5b_ack_n", ack_cyc.size(), 1);
    chk("t5b_done", qi(done_cyc, 0), 2);
    chk("t5b_nord", rd_cyc.size(), 0);
    chk("t5b_lerr", 32'(bus.oLEN_ERR), 32'h1);

    // 6: reset in the middle of a burst
    clr(); req(23'h500, 5'd8); run(3);
    rst = 1'b1;
    step();
    chk("t6_rst_flags", flags(), 32'h0);
    chk("t6_rst_addr", 32'(bus.oMEM_ADDR), 32'h0);
    rst = 1'b0;
    run(14);
    chk("t6_gv_n", gv_cyc.size(), 0);
    chk("t6_done_n", done_cyc.size(), 0);
    clr(); req(23'h600, 5'd2); run(10);
    chk("t6_ack", qi(ack_cyc, 0), 1);
    chk("t6_gv0", qd(gv_dat, 0), 32'hA500_0600);
    chk("t6_gv1", qd(gv_dat, 1), 32'hA500_0601);
    chk("t6_done", qi(done_cyc, 0), 6);
    chk("t6_conf", 32'(bus.oCONFLICT), 32'h0);

    chk("both_valid", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
